uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one 8N1 UART transmit line between NUM_REQ byte sources.
- Round-robin arbiter with a valid/ready handshake per requester, feeding an integrated serializer.
- Baud timing comes from a clock-enable counter on clk; no derived clocks.
- Sits between on-chip producers (status, debug, sensor loggers) and the board's serial TX pin.

Parameters:
- CLK_FREQ, 27000000, system clock in Hz (documentation only; not used in logic).
- BAUD_DIV, 2812, clk cycles per bit (27 MHz / 9600); legal range 2..65535.
- NUM_REQ, 4, number of requesters; legal range 2..8.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte pending.
- req_data  in  8*NUM_REQ  byte of requester i in bits [8i+7:8i]; must be stable while valid.
- req_ready  out  NUM_REQ  one-hot accept strobe; a transfer occurs when valid[i] & ready[i].
- tx  out  1  serial line; idles high.
- busy  out  1  high from the cycle after accept through the last stop-bit cycle.
- grant_id  out  3  index of the requester whose frame is in flight; holds its value after the frame.

Behaviour:
- Reset values: tx=1, busy=0, req_ready=0, grant_id=0, state=IDLE, baud counter=0, last_grant=NUM_REQ-1 (so requester 0 wins first).
- States: IDLE, START, DATA, STOP (plus PARITY when the optional feature is compiled in).
- Bit timing: each state bit lasts exactly BAUD_DIV clk cycles. The counter runs 0..BAUD_DIV-1 and is cleared on every accept. The end of a bit is the cycle where the counter equals BAUD_DIV-1.
- IDLE, arbitration:
  - When any req_valid is set, the grant goes to the first valid index strictly after last_grant, searching upward with wrap-around.
  - req_ready[g] is combinational, high only in that IDLE cycle.
  - On accept: latch req_data[g] into the shift register, set grant_id=g and last_grant=g, then go to START.
  - Only one accept per frame.
- START: tx=0 for one bit, then DATA with bit index 0.
- DATA:
  - tx = shift[0]; LSB first.
  - At each bit end, shift right and increment the 3-bit index.
  - After bit 7 ends, go to STOP (or PARITY).
- STOP: tx=1 for one bit, then IDLE.
- Latency:
  - The accept cycle is T. tx falls at T+1.
  - The frame occupies T+1 .. T+10*BAUD_DIV.
  - busy=1 over the same cycles.
- Back-to-back: if any valid is pending in the first IDLE cycle after STOP, the next accept happens in that cycle. The next start bit begins one clk after the stop bit ends (one-cycle idle gap, deterministic).
- Fairness: with all NUM_REQ requesters continuously valid, grants cycle 0,1,2,...,NUM_REQ-1,0,...
- Valid withdrawn before ready: legal, no side effect; the arbiter re-evaluates every IDLE cycle.
- req_ready is never asserted outside IDLE, and is never asserted to a requester whose valid is low.
- Reset mid-frame: tx returns to 1 asynchronously and the frame is abandoned. The interrupted requester is not re-served automatically; it must re-present its byte.
- tx is registered (glitch-free). All outputs are registered except req_ready.

Optional Feature:
- Macro: UART_TX_ARB_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for one bit.
  - Frame length is 11*BAUD_DIV cycles, with busy extended to match.
- Undefined: no PARITY state; the frame is 10 bits, 8N1.

Test Plan:
- Single frame: BAUD_DIV=4, req_valid=0001, data0=0xA5.
  - ready[0] is high for 1 cycle.
  - tx sequence per 4 cycles: 0,1,0,1,0,0,1,0,1,1.
  - busy is high for exactly 40 cycles; grant_id=0.
- Round-robin: all four valid continuously with data 0x11,0x22,0x33,0x44.
  - Frames are sent in order 0x11,0x22,0x33,0x44,0x11.
  - Each accept occurs 41 cycles after the previous one.
- Skip-and-wrap: last_grant=2, valid=0011.
  - The next grant is 0, then 1, then 0.
  - Requesters 2 and 3 never see ready.
- Withdraw: valid[1] pulses for 1 cycle while busy; no accept.
  - After STOP with no valid, tx stays 1 and busy=0 indefinitely.
- Mid-frame reset: assert rst during DATA bit 3 of 0x00.
  - tx=1 in the same cycle; busy=0.
  - After release with valid=0001, a full fresh frame is sent, granted to requester 0.
- Parity build (UART_TX_ARB_PARITY_EN): data 0x07.
  - Parity bit is 1; frame is 11 bits (44 cycles); stop bit follows parity.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one 8N1 UART transmit line between NUM_REQ byte sources. A
// round-robin arbiter picks one pending requester per frame through a
// valid/ready handshake and hands its byte to the serializer. Bit timing
// comes from a clock-enable counter on clk; there are no derived clocks.
//
// Optional build: define UART_TX_ARB_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit (11-bit frame).
//
// Parameters:
//   CLK_FREQ  system clock in Hz (informational only)
//   BAUD_DIV  clk cycles per bit, 2..65535
//   NUM_REQ   number of requesters, 2..8
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   [NUM_REQ]    requester i has a byte pending
//   req_data   in   [8*NUM_REQ]  byte of requester i in bits [8i+7:8i]
//   req_ready  out  [NUM_REQ]    one-hot accept strobe (combinational)
//   tx         out  serial line, idles high (registered)
//   busy       out  high from the cycle after accept through the stop bit
//   grant_id   out  [3] requester whose frame is in flight; holds afterwards
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line high; arbitrate and accept one byte per frame
// START  | start bit (tx low) for BAUD_DIV cycles
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (parity build only)
// STOP   | stop bit (tx high), then back to IDLE

module uart_tx_arbiter #(
    parameter int CLK_FREQ = 27000000,
    parameter int BAUD_DIV = 2812,
    parameter int NUM_REQ  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [2:0]           grant_id
);

    if (BAUD_DIV < 2 || BAUD_DIV > 65535 || NUM_REQ < 2 || NUM_REQ > 8 || CLK_FREQ < 1) begin : g_bad_params
        $error("uart_tx_arbiter: parameter out of range");
    end

    localparam logic [15:0] BIT_END = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic [2:0]  last_grant;
    logic        bit_end;

    logic        pick_found;
    logic [2:0]  pick_idx;
    logic [7:0]  pick_data;

`ifdef UART_TX_ARB_PARITY_EN
    logic        parity_bit;
`endif

    assign bit_end = (baud_cnt == BIT_END);

    // Search upward from the requester after last_grant, wrapping around.
    // Outer loop is the search distance so the nearest valid index wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        pick_data  = 8'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pick_found && req_valid[i] &&
                    (i == (int'(last_grant) + k) % NUM_REQ)) begin
                    pick_found = 1'b1;
                    pick_idx   = 3'(i);
                    pick_data  = req_data[i*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (state == IDLE) && pick_found && (pick_idx == 3'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            last_grant <= 3'(NUM_REQ - 1);
            grant_id   <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
`ifdef UART_TX_ARB_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            // Counter only runs while a frame is on the line; it sits at 0
            // in IDLE so the accept cycle starts a full-length start bit.
            if (state != IDLE) begin
                baud_cnt <= bit_end ? 16'd0 : baud_cnt + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (pick_found) begin
                        shift      <= pick_data;
                        grant_id   <= pick_idx;
                        last_grant <= pick_idx;
                        baud_cnt   <= '0;
                        bit_idx    <= '0;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
`ifdef UART_TX_ARB_PARITY_EN
                        parity_bit <= ^pick_data;
`endif
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx      <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_ARB_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            // tx is registered, so present the next bit now.
                            tx      <= shift[1];
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_ARB_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int BAUD = 4;
    localparam int NREQ = 4;
`ifdef UART_TX_ARB_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * BAUD;

    logic             clk;
    logic             rst;
    logic [NREQ-1:0]  req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]  req_ready;
    logic             tx;
    logic             busy;
    logic [2:0]       grant_id;

    uart_tx_arbiter #(
        .CLK_FREQ(27000000),
        .BAUD_DIV(BAUD),
        .NUM_REQ (NREQ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .tx       (tx),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: a frame is a list of line levels, each held BAUD cycles.
    int   m_left;
    int   m_t;
    int   m_last;
    int   m_grant;
    logic m_bits [0:10];
    int   m_accepts;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_left  = 0;
        m_t     = 0;
        m_last  = NREQ - 1;
        m_grant = 0;
    endtask

    // Called at posedge+1: drive inputs, check mid-cycle, then advance model.
    task automatic cycle(input logic [NREQ-1:0] v);
        logic [NREQ-1:0] exp_ready;
        logic            exp_tx;
        logic            exp_busy;
        logic [7:0]      d;
        int              g;
        req_valid = v;
        @(negedge clk);
        exp_ready = '0;
        g = -1;
        if (m_left == 0) begin
            exp_tx   = 1'b1;
            exp_busy = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && v[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
        end else begin
            exp_tx   = m_bits[m_t / BAUD];
            exp_busy = 1'b1;
        end
        chk("tx", 32'(tx), 32'(exp_tx));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("grant_id", 32'(grant_id), 32'(m_grant));
        if (g >= 0) begin
            d = req_data[g*8 +: 8];
            m_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) m_bits[1+i] = d[i];
`ifdef UART_TX_ARB_PARITY_EN
            m_bits[9]  = ^d;
            m_bits[10] = 1'b1;
`else
            m_bits[9]  = 1'b1;
`endif
            m_last  = g;
            m_grant = g;
            m_left  = FRAME;
            m_t     = 0;
            m_accepts++;
        end else if (m_left > 0) begin
            m_t++;
            m_left--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle('0);
    endtask

    task automatic pulse_reset();
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int a0;
        logic [NREQ-1:0] v;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        m_accepts = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_grant", 32'(grant_id), 32'd0);
        rst = 1'b0;

        // single frame 0xA5 from requester 0
        req_data = 32'h0000_00A5;
        idle_cycles(2);
        cycle(4'b0001);
        idle_cycles(FRAME + 8);

        // round robin, all valid continuously
        req_data = 32'h4433_2211;
        a0 = m_accepts;
        for (int i = 0; i < 5 * (FRAME + 1); i++) cycle(4'b1111);
        chk("rr_accept_count", 32'(m_accepts - a0), 32'd5);
        idle_cycles(FRAME + 4);

        // skip-and-wrap: last grant 2, then only 0 and 1 valid
        req_data = 32'h5A3C_C35A;
        cycle(4'b0100);
        chk("skip_last2", 32'(m_last), 32'd2);
        for (int i = 0; i < 3 * (FRAME + 1) + 1; i++) cycle(4'b0011);
        idle_cycles(FRAME + 4);

        // withdraw: one-cycle pulse on valid[1] while busy, then long idle
        req_data = 32'h0000_9600;
        cycle(4'b0001);
        idle_cycles(10);
        cycle(4'b0010);
        idle_cycles(FRAME + 60);

        // mid-frame reset during data bit 3 of 0x00
        req_data = 32'h0000_0000;
        cycle(4'b0001);
        idle_cycles(BAUD * 4 + 1);
        pulse_reset();
        req_data = 32'h0000_00C3;
        cycle(4'b0001);
        chk("post_reset_grant0", 32'(m_grant), 32'd0);
        idle_cycles(FRAME + 4);

`ifdef UART_TX_ARB_PARITY_EN
        req_data = 32'h0000_0007;
        cycle(4'b0001);
        idle_cycles(FRAME + 4);
`endif

        // randomized traffic with sparse valids and changing data
        for (int i = 0; i < 800; i++) begin
            for (int r = 0; r < NREQ; r++) v[r] = ($urandom_range(0, 3) == 0);
            if (v == '0) req_data = {$urandom, $urandom} [31:0];
            cycle(v);
        end
        idle_cycles(FRAME + 4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
